// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memory opcodes, FSM states and op-class helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    function automatic logic is_store(input lsu_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic is_load(input lsu_op_e op);
        return !is_store(op);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Per-opcode data steering: store byte enables / lane replication, alignment check,
// and load lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] lane_s;

    // Store enables, replicated write data and the misalignment flag.
    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (op)
            SB: begin
                be         = 4'b0001 << addr_lo;
                wdata      = {4{store_data[7:0]}};
                misaligned = 1'b0;
            end
            SH: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            SW: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = (addr_lo != 2'b00);
            end
            LH, LHU: begin
                misaligned = addr_lo[0];
            end
            LW: begin
                misaligned = (addr_lo != 2'b00);
            end
            LB, LBU: begin
                misaligned = 1'b0;
            end
            default: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = 1'b0;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend to a full word.
    always_comb begin
        lane_s = rdata >> {addr_lo, 3'b000};
        case (op)
            LB:      load_data = {{24{lane_s[7]}}, lane_s[7:0]};
            LH:      load_data = {{16{lane_s[15]}}, lane_s[15:0]};
            LBU:     load_data = {24'd0, lane_s[7:0]};
            LHU:     load_data = {16'd0, lane_s[15:0]};
            LW:      load_data = rdata;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request/grant/response data-memory master with
// registered writeback and error outputs, plus an optional response timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  lsu_op_e     mem_op_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    lsu_state_e  state_r;
    lsu_op_e     op_r;
    logic [31:0] addr_r;
    logic [4:0]  rd_r;
    logic [31:0] cnt_r;

    lsu_op_e     align_op_s;
    logic [1:0]  align_addr_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        misaligned_s;
    logic [31:0] load_data_s;
    logic        ld_we_s;
    logic        timeout_s;

    // The align block sees the incoming instruction while idle and the latched one afterwards.
    always_comb begin
        if (state_r == IDLE) begin
            align_op_s   = mem_op_i;
            align_addr_s = addr_i[1:0];
        end else begin
            align_op_s   = op_r;
            align_addr_s = addr_r[1:0];
        end
        ld_we_s = is_load(op_r) && (rd_r != 5'd0);
        if (TIMEOUT_CYCLES != 32'd0) begin
            timeout_s = ((cnt_r + 32'd1) == TIMEOUT_CYCLES);
        end else begin
            timeout_s = 1'b0;
        end
    end

    lsu_align u_align (
        .op         (align_op_s),
        .addr_lo    (align_addr_s),
        .store_data (store_data_i),
        .rdata      (dmem_rdata_i),
        .be         (be_s),
        .wdata      (wdata_s),
        .misaligned (misaligned_s),
        .load_data  (load_data_s)
    );

    // Transaction FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            op_r         <= LB;
            addr_r       <= 32'd0;
            rd_r         <= 5'd0;
            cnt_r        <= 32'd0;
            ready_o      <= 1'b1;
            dmem_req_o   <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'd0;
            dmem_wdata_o <= 32'd0;
            wb_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_rd_o      <= 5'd0;
            wb_data_o    <= 32'd0;
            err_o        <= 1'b0;
            err_addr_o   <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        op_r    <= mem_op_i;
                        addr_r  <= addr_i;
                        rd_r    <= rd_i;
                        ready_o <= 1'b0;
                        if (misaligned_s) begin
                            state_r    <= ERR;
                            err_o      <= 1'b1;
                            err_addr_o <= addr_i;
                        end else begin
                            state_r      <= REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_addr_o  <= {addr_i[31:2], 2'b00};
                            dmem_we_o    <= is_store(mem_op_i);
                            dmem_be_o    <= be_s;
                            dmem_wdata_o <= wdata_s;
                        end
                    end
                end
                REQ: begin
                    // Request fields stay frozen until the bus grants.
                    if (dmem_gnt_i) begin
                        state_r    <= WAIT;
                        dmem_req_o <= 1'b0;
                        cnt_r      <= 32'd0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state_r    <= RESP;
                        wb_valid_o <= 1'b1;
                        wb_we_o    <= ld_we_s;
                        wb_rd_o    <= rd_r;
                        wb_data_o  <= ld_we_s ? load_data_s : 32'd0;
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        err_o      <= 1'b1;
                        err_addr_o <= addr_r;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    wb_valid_o <= 1'b0;
                    wb_we_o    <= 1'b0;
                    ready_o    <= 1'b1;
                end
                ERR: begin
                    state_r <= IDLE;
                    err_o   <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    dmem_req_o <= 1'b0;
                    wb_valid_o <= 1'b0;
                    wb_we_o    <= 1'b0;
                    err_o      <= 1'b0;
                    ready_o    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected writeback/error results into a queue,
// an independent monitor pops and compares whenever the DUT presents a result.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    lsu_op_e     mem_op_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;
    logic [31:0] err_addr_o;

    typedef struct packed {
        logic        is_err;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    lsu #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .addr_i(addr_i), .store_data_i(store_data_i), .mem_op_i(mem_op_i), .rd_i(rd_i),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
        .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .err_o(err_o), .err_addr_o(err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    exp_t mon_e;
    logic mon_ok;
    always @(negedge clk_i) begin
        if (rst_ni && (wb_valid_o || err_o)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: wb_valid=%0b err=%0b expected=none", wb_valid_o, err_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err)
                    mon_ok = err_o && !wb_valid_o && (err_addr_o == mon_e.data);
                else
                    mon_ok = wb_valid_o && !err_o && (wb_we_o == mon_e.we) &&
                             (wb_rd_o == mon_e.rd) && (wb_data_o == mon_e.data);
                if (!mon_ok) begin
                    bad++;
                    $display("FAIL result: got wb_valid=%0b err=%0b we=%0b rd=%0d data=%h err_addr=%h expected is_err=%0b we=%0b rd=%0d data=%h",
                             wb_valid_o, err_o, wb_we_o, wb_rd_o, wb_data_o, err_addr_o,
                             mon_e.is_err, mon_e.we, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic push_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{is_err: 1'b0, we: we, rd: rd, data: data});
    endtask

    task automatic push_err(input logic [31:0] a);
        exp_q.push_back('{is_err: 1'b1, we: 1'b0, rd: 5'd0, data: a});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("ready_wait", {31'd0, ready_o}, 32'd1);
    endtask

    // Present one instruction for one accepting edge; returns in cycle N+1.
    task automatic accept(input lsu_op_e op, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rd);
        wait_ready();
        valid_i = 1'b1; mem_op_i = op; addr_i = a; store_data_i = d; rd_i = rd;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    // Hold grant low gdly cycles, then grant; checks request stability every cycle.
    task automatic bus(input int gdly, input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic ewe);
        for (int k = 0; k <= gdly; k++) begin
            dmem_gnt_i = (k == gdly);
            @(negedge clk_i);
            chk("req", {31'd0, dmem_req_o}, 32'd1);
            chk("req_addr", dmem_addr_o, ea);
            chk("req_be", {28'd0, dmem_be_o}, {28'd0, ebe});
            chk("req_wdata", dmem_wdata_o, ewd);
            chk("req_we", {31'd0, dmem_we_o}, {31'd0, ewe});
            chk("busy_ready", {31'd0, ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        dmem_gnt_i = 1'b0;
    endtask

    // Return read data in the current WAIT cycle and check the writeback pulse next cycle.
    task automatic respond(input logic [31:0] rdata);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("wb_pulse", {31'd0, wb_valid_o}, 32'd1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; addr_i = 32'd0; store_data_i = 32'd0;
        mem_op_i = LB; rd_i = 5'd0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        dmem_rdata_i = 32'd0;

        @(negedge clk_i);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_flags", {28'd0, dmem_we_o, wb_valid_o, wb_we_o, err_o}, 32'd0);
        chk("rst_wb", {wb_data_o[26:0], wb_rd_o}, 32'd0);
        chk("rst_err_addr", err_addr_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // SW full word, zero-wait grant and response
        push_wb(1'b0, 5'd7, 32'd0);
        accept(SW, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7);
        bus(0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1'b1);
        respond(32'h0);

        // LB / LBU top byte
        push_wb(1'b1, 5'd5, 32'hFFFF_FF80);
        accept(LB, 32'h0000_0203, 32'h0, 5'd5);
        bus(0, 32'h0000_0200, 4'hF, 32'h0, 1'b0);
        respond(32'h80FF_1234);
        push_wb(1'b1, 5'd5, 32'h0000_0080);
        accept(LBU, 32'h0000_0203, 32'h0, 5'd5);
        bus(0, 32'h0000_0200, 4'hF, 32'h0, 1'b0);
        respond(32'h80FF_1234);

        // LH upper half sign-extends; LHU lower half zero-extends
        push_wb(1'b1, 5'd12, 32'hFFFF_80FF);
        accept(LH, 32'h0000_0202, 32'h0, 5'd12);
        bus(0, 32'h0000_0200, 4'hF, 32'h0, 1'b0);
        respond(32'h80FF_1234);
        push_wb(1'b1, 5'd13, 32'h0000_9234);
        accept(LHU, 32'h0000_0200, 32'h0, 5'd13);
        bus(0, 32'h0000_0200, 4'hF, 32'h0, 1'b0);
        respond(32'h80FF_9234);

        // SH upper half with three-cycle grant stall
        push_wb(1'b0, 5'd3, 32'd0);
        accept(SH, 32'h0000_0102, 32'h0000_ABCD, 5'd3);
        bus(3, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 1'b1);
        respond(32'h0);

        // SB byte lane 1
        push_wb(1'b0, 5'd1, 32'd0);
        accept(SB, 32'h0000_0101, 32'h1234_5678, 5'd1);
        bus(1, 32'h0000_0100, 4'b0010, 32'h7878_7878, 1'b1);
        respond(32'h0);

        // Load to x0 still uses the bus but does not write back
        push_wb(1'b0, 5'd0, 32'd0);
        accept(LW, 32'h0000_0500, 32'h0, 5'd0);
        bus(0, 32'h0000_0500, 4'hF, 32'h0, 1'b0);
        respond(32'hCAFE_F00D);

        // Misaligned LW: error pulse, no bus request
        push_err(32'h0000_0101);
        accept(LW, 32'h0000_0101, 32'h0, 5'd2);
        @(negedge clk_i);
        chk("mis_no_req", {31'd0, dmem_req_o}, 32'd0);
        chk("mis_err", {31'd0, err_o}, 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("mis_ready_n2", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); #1;

        // Timeout after four silent WAIT cycles; late rvalid ignored
        push_err(32'h0000_0300);
        accept(LW, 32'h0000_0300, 32'h0, 5'd4);
        bus(0, 32'h0000_0300, 4'hF, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("to_wait_no_err", {31'd0, err_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
        @(negedge clk_i);
        chk("to_err", {31'd0, err_o}, 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("to_late_rvalid", {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("to_late_rvalid2", {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk_i); #1;

        // Reset while waiting for the response
        accept(LW, 32'h0000_0400, 32'h0, 5'd9);
        bus(0, 32'h0000_0400, 4'hF, 32'h0, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_flags", {27'd0, dmem_req_o, dmem_we_o, wb_valid_o, wb_we_o, err_o}, 32'd0);
        chk("mid_rst_addr", dmem_addr_o, 32'd0);
        chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("stale_rvalid", {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        push_wb(1'b1, 5'd9, 32'h1234_5678);
        accept(LW, 32'h0000_0404, 32'h0, 5'd9);
        bus(0, 32'h0000_0404, 4'hF, 32'h0, 1'b0);
        respond(32'h1234_5678);

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
